// File: rtl/asmd_booth_multiplier_if.sv
// Operand/result bundle for the Booth multiplier: start/ready request handshake plus the done-qualified product.
interface asmd_booth_multiplier_if #(
    parameter int word_length = 8
);
    logic [word_length-1:0]   word0;
    logic [word_length-1:0]   word1;
    logic                     signed_mode;
    logic                     start;
    logic [2*word_length-1:0] product;
    logic                     ready;
    logic                     done;

    modport master (
        output word0, word1, signed_mode, start,
        input  product, ready, done
    );

    modport slave (
        input  word0, word1, signed_mode, start,
        output product, ready, done
    );
endinterface

// File: rtl/asmd_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, signed/unsigned per op; latency W+2 edges (1 edge when an operand is zero).
// Backpressure: start is only taken while ready=1 in IDLE; requests made while busy are dropped, not queued.
module asmd_booth_multiplier #(
    parameter int word_length = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    asmd_booth_multiplier_if.slave  bus
);
    localparam int W  = word_length;
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W+1:0]    acc;
    logic [W:0]      mcand;
    logic [W:0]      mplier;
    logic            q_m1;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  product_q;
    logic            done_q;

    logic [W:0]      ext0;
    logic [W:0]      ext1;
    logic            zero_op;
    logic [W+1:0]    m_wide;
    logic [W+1:0]    booth_sum;

    // Operands are widened by one bit so unsigned values look positive to the signed Booth recoding.
    always_comb begin
        ext0    = {bus.signed_mode & bus.word0[W-1], bus.word0};
        ext1    = {bus.signed_mode & bus.word1[W-1], bus.word1};
        zero_op = (bus.word0 == '0) || (bus.word1 == '0);
        m_wide  = {mcand[W], mcand};
    end

    always_comb begin
        booth_sum = acc;
        case ({mplier[0], q_m1})
            2'b01:   booth_sum = acc + m_wide;
            2'b10:   booth_sum = acc - m_wide;
            default: booth_sum = acc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                // count==1 means this edge performs the final (W+1)th step
                if (count == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            q_m1      <= 1'b0;
            count     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        mcand  <= ext0;
                        // Fast path skips RUN, so Q must already hold the zero result.
                        mplier <= zero_op ? '0 : ext1;
                        q_m1   <= 1'b0;
                        count  <= CW'(W + 1);
                    end
                end
                RUN: begin
                    acc    <= {booth_sum[W+1], booth_sum[W+1:1]};
                    mplier <= {booth_sum[0], mplier[W:1]};
                    q_m1   <= mplier[0];
                    count  <= count - CW'(1);
                end
                DONE: begin
                    product_q <= {acc[W-2:0], mplier};
                    done_q    <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.product = product_q;
    assign bus.done    = done_q;
    assign bus.ready   = (state == IDLE);
endmodule
